speed_ctrl: RTL
===============

# speed_ctrl

Pipelined, parametrised successor to the combinational front-speed calculation in the balance-control path. It accepts saturated pitch-error samples with a valid strobe and derives the pitch derivative internally from a sample-history buffer of configurable depth. It saturates every intermediate term and outputs a registered forward-speed command with a valid flag and an over-speed flag. It sits between the pitch-error saturation logic and the motor-drive/steering stage.

## Interface
- ERR_W, 10, signed pitch-error width
- DIFF_W, 6, signed width to which the derivative difference saturates
- THR_W, 9, unsigned thrust width
- OUT_W, 13, signed output width
- D_DEPTH, 4, history depth; derivative = current sample − sample D_DEPTH valid samples earlier (≥2)
- D_GAIN, 9, derivative gain, unsigned integer
- MIN_RUN_SPEED, 512, speed offset
- TOO_FAST, 1536, over-speed threshold
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  rider present/enable; low forces IDLE
- vld  in  1  new sample on ptch_err_sat/thrst this cycle
- ptch_err_sat  in  ERR_W  signed pitch error
- thrst  in  THR_W  unsigned thrust
- frnt_spd  out  OUT_W  signed speed command, registered
- spd_vld  out  1  one-cycle pulse; frnt_spd updated this cycle
- too_fast  out  1  registered; frnt_spd ≥ TOO_FAST
- busy_fill  out  1  high in FILL (derivative not yet valid)

## Operation
- States: IDLE, FILL, RUN. Transitions are evaluated at each rising edge.
- IDLE: history cleared, fill_cnt=0. en=1 → FILL. vld ignored.
- FILL: each accepted vld pushes a sample and increments fill_cnt. dterm is forced to 0. The vld that brings fill_cnt to D_DEPTH moves to RUN. That sample still uses dterm=0.
- RUN: diff = err − hist[D_DEPTH−1], taken before the shift. diff is saturated to DIFF_W signed, so [−32,31] at default. dterm = diff_sat × D_GAIN, signed.
- pterm = (err>>>1) + (err>>>4). Shifts are arithmetic.
- sum = MIN_RUN_SPEED + thrst − pterm − dterm. The sum is computed in OUT_W+2 bits, then saturated to OUT_W signed.
- too_fast = (sum_sat ≥ TOO_FAST), compared signed.
- en=0 from any state → IDLE at that edge. History, fill_cnt and stage-1 valid are cleared. frnt_spd, spd_vld and too_fast go to 0 at the same edge, so in-flight samples are dropped.
- rst=1 has the same effect as en=0 and overrides en and vld.
- vld on consecutive cycles is legal. Throughput is one sample per cycle with no stall.

## Timing
- Reset values: frnt_spd=0, spd_vld=0, too_fast=0, busy_fill=0, state=IDLE.
- Stage 1, at the edge sampling vld: registers diff_sat (or 0 in FILL), pterm, thrst, and s1_vld. The history shifts at this edge.
- Stage 2, at the next edge: registers frnt_spd and too_fast, and pulses spd_vld for one cycle.
- Latency: vld high before edge N gives spd_vld high after edge N+1.
- busy_fill is registered and equals (state==FILL). It rises one edge after the en rise.
- frnt_spd holds its value between spd_vld pulses.
- Simultaneous en fall and vld: the sample is not accepted and its output is not produced.

## Structure
- Package speed_pkg holds the state enum (IDLE/FILL/RUN) and the default values of MIN_RUN_SPEED, TOO_FAST, D_GAIN and D_DEPTH.
- Sub-module ptch_hist contains the parametrised D_DEPTH×ERR_W shift buffer, fill counter and saturated difference. Its ports are clk, rst, clr, push, din, diff_sat and full.
- The top level contains the FSM, the pterm/dterm/sum pipeline and the saturation logic.

## Test plan
- Reset: rst=1 for 2 cycles while en=1 and vld pulses are applied → all outputs 0, no spd_vld, state IDLE.
- FILL: en=1, thrst=100, err=+80 for 4 vld → each frnt_spd=567 (pterm 45, dterm 0), spd_vld 2 edges after each vld, busy_fill drops after the 4th.
- RUN derivative saturation: fill with err=0, thrst=0, then err=+40 → diff 40 saturates to 31, dterm 279, pterm 22, frnt_spd=211, too_fast=0.
- Over-speed: fill with err=0, thrst=511, then err=−512 → pterm −288, dterm −288, frnt_spd=1599, too_fast=1.
- en drop mid-pipeline: vld at cycle k, en=0 at cycle k+1 → no spd_vld, frnt_spd=0. Re-enabling restarts FILL with dterm=0 for 4 samples.
- Back-to-back: 8 vld on consecutive cycles with a ramped err → 8 consecutive spd_vld pulses, each value matching the model, with no drops.

Source files
------------

// File: rtl/speed_pkg.sv
// Shared definitions for the forward-speed pipeline: FSM states and default tuning constants.
package speed_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam int DEF_MIN_RUN_SPEED = 512;
   localparam int DEF_TOO_FAST      = 1536;
   localparam int DEF_D_GAIN        = 9;
   localparam int DEF_D_DEPTH       = 4;

endpackage

// File: rtl/ptch_hist.sv
// Pitch-error history buffer with fill counter and saturated derivative difference.
module ptch_hist
   import speed_pkg::*;
#(
   parameter int ERR_W   = 10,
   parameter int DIFF_W  = 6,
   parameter int D_DEPTH = DEF_D_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              push,
   input  logic [ERR_W-1:0]  din,
   output logic [DIFF_W-1:0] diff_sat,
   output logic              full
);

   localparam int CNT_W = $clog2(D_DEPTH + 1);
   localparam int DW    = ERR_W + 1;
   localparam int DMAX  = 2**(DIFF_W-1) - 1;
   localparam int DMIN  = -(2**(DIFF_W-1));

   logic [ERR_W-1:0]     hist [D_DEPTH];
   logic [CNT_W-1:0]     fill_cnt;
   logic signed [DW-1:0] diff;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int unsigned i = 0; i < D_DEPTH; i++) hist[i] <= '0;
         fill_cnt <= '0;
      end else if (push) begin
         hist[0] <= din;
         for (int unsigned i = 1; i < D_DEPTH; i++) hist[i] <= hist[i-1];
         if (fill_cnt != CNT_W'(D_DEPTH)) fill_cnt <= fill_cnt + CNT_W'(1);
      end
   end

   // Asserted for the push that completes the fill, so the FSM can leave FILL on that same edge.
   assign full = push && (fill_cnt == CNT_W'(D_DEPTH - 1));

   always_comb begin
      diff = $signed({din[ERR_W-1], din}) -
             $signed({hist[D_DEPTH-1][ERR_W-1], hist[D_DEPTH-1]});
      if (diff > DW'(DMAX))
         diff_sat = DIFF_W'(DMAX);
      else if (diff < DW'(DMIN))
         diff_sat = DIFF_W'(DMIN);
      else
         diff_sat = diff[DIFF_W-1:0];
   end

endmodule

// File: rtl/speed_ctrl.sv
// Two-stage forward-speed command: pitch P/D terms, thrust offset, saturation and over-speed flag.
module speed_ctrl
   import speed_pkg::*;
#(
   parameter int ERR_W         = 10,
   parameter int DIFF_W        = 6,
   parameter int THR_W         = 9,
   parameter int OUT_W         = 13,
   parameter int D_DEPTH       = DEF_D_DEPTH,
   parameter int D_GAIN        = DEF_D_GAIN,
   parameter int MIN_RUN_SPEED = DEF_MIN_RUN_SPEED,
   parameter int TOO_FAST      = DEF_TOO_FAST
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             vld,
   input  logic [ERR_W-1:0] ptch_err_sat,
   input  logic [THR_W-1:0] thrst,
   output logic [OUT_W-1:0] frnt_spd,
   output logic             spd_vld,
   output logic             too_fast,
   output logic             busy_fill
);

   localparam int SUM_W = OUT_W + 2;
   localparam int OMAX  = 2**(OUT_W-1) - 1;
   localparam int OMIN  = -(2**(OUT_W-1));

   state_t state, next_state;
   logic   kill, accept, hist_clr, hist_full;
   logic [DIFF_W-1:0] diff_sat;

   logic signed [ERR_W-1:0]  err_s, pterm;
   logic signed [DIFF_W-1:0] s1_dsat;
   logic signed [ERR_W-1:0]  s1_pterm;
   logic [THR_W-1:0]         s1_thrst;
   logic                     s1_vld;

   logic signed [SUM_W-1:0]  dterm_x, pterm_x, thr_x, sum_x;
   logic signed [OUT_W-1:0]  sum_sat;
   logic                     fast;

   assign kill     = rst || !en;
   assign accept   = vld && en && !rst && (state != IDLE);
   assign hist_clr = !en || (state == IDLE);

   ptch_hist #(
      .ERR_W  (ERR_W),
      .DIFF_W (DIFF_W),
      .D_DEPTH(D_DEPTH)
   ) u_hist (
      .clk     (clk),
      .rst     (rst),
      .clr     (hist_clr),
      .push    (accept),
      .din     (ptch_err_sat),
      .diff_sat(diff_sat),
      .full    (hist_full)
   );

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (en) next_state = FILL;
         FILL:    if (accept && hist_full) next_state = RUN;
         RUN:     next_state = RUN;
         default: next_state = IDLE;
      endcase
      if (!en) next_state = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy_fill <= 1'b0;
      end else begin
         state     <= next_state;
         busy_fill <= (next_state == FILL);
      end
   end

   assign err_s = ptch_err_sat;
   assign pterm = (err_s >>> 1) + (err_s >>> 4);

   always_ff @(posedge clk) begin
      if (kill) begin
         s1_vld   <= 1'b0;
         s1_dsat  <= '0;
         s1_pterm <= '0;
         s1_thrst <= '0;
      end else begin
         s1_vld <= accept;
         if (accept) begin
            s1_dsat  <= (state == RUN) ? diff_sat : '0;
            s1_pterm <= pterm;
            s1_thrst <= thrst;
         end
      end
   end

   always_comb begin
      dterm_x = SUM_W'(s1_dsat) * SUM_W'(D_GAIN);
      pterm_x = SUM_W'(s1_pterm);
      thr_x   = SUM_W'(s1_thrst);
      sum_x   = SUM_W'(MIN_RUN_SPEED) + thr_x - pterm_x - dterm_x;
      if (sum_x > SUM_W'(OMAX))
         sum_sat = OUT_W'(OMAX);
      else if (sum_x < SUM_W'(OMIN))
         sum_sat = OUT_W'(OMIN);
      else
         sum_sat = sum_x[OUT_W-1:0];
      fast = (sum_sat >= OUT_W'(TOO_FAST));
   end

   always_ff @(posedge clk) begin
      if (kill) begin
         frnt_spd <= '0;
         too_fast <= 1'b0;
         spd_vld  <= 1'b0;
      end else begin
         spd_vld <= s1_vld;
         if (s1_vld) begin
            frnt_spd <= sum_sat;
            too_fast <= fast;
         end
      end
   end

endmodule
